// File: rtl/s_mem_pkg.sv
// Shared types and defaults for the RC4 S-memory arbiter slice.
package s_mem_pkg;

  localparam int unsigned S_ADDR_W  = 8;
  localparam int unsigned S_DATA_W  = 8;
  localparam int unsigned S_NUM_REQ = 3;

  localparam int unsigned REQ_INIT = 0;
  localparam int unsigned REQ_KSA  = 1;
  localparam int unsigned REQ_PRGA = 2;

  typedef logic [$clog2(S_NUM_REQ)-1:0] owner_t;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/s_mem_arbiter_rr_pick.sv
// Find-first-set over req, starting at ptr and wrapping around.
module rr_pick #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         pick,
  output logic                 found
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s_mem_arbiter.sv
// Round-robin, grant-locked arbiter for the single-port RC4 S-memory.
// Read data is tagged back to its issuer through a valid+index pipeline.
module s_mem_arbiter
  import s_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ    = S_NUM_REQ,
  parameter int unsigned ADDR_W     = S_ADDR_W,
  parameter int unsigned DATA_W     = S_DATA_W,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_HOLD   = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          rd,
  input  logic [NUM_REQ-1:0]          wr,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data,
  output logic                        mem_wren,
  input  logic [DATA_W-1:0]           mem_q,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  owner_id,
  output logic                        starve_err
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned IW = RD_LATENCY * OW;

  arb_state_t          state;
  logic [OW-1:0]       ptr;
  logic [OW-1:0]       pick_ptr;
  logic [OW-1:0]       owner_inc;
  logic [OW-1:0]       pick_id;
  logic [NUM_REQ-1:0]  pick;
  logic                found;
  logic                others_req;
  logic [HW-1:0]       hold;
  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_a [NUM_REQ];
  logic [RD_LATENCY-1:0] vld_sr;
  logic [IW-1:0]       idx_sr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
  end

  // On release the search starts just past the outgoing owner.
  assign owner_inc  = (owner_id == OW'(NUM_REQ - 1)) ? '0 : owner_id + 1'b1;
  assign pick_ptr   = (state == OWN) ? owner_inc : ptr;
  assign others_req = |(req & ~gnt);

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .pick  (pick),
    .found (found)
  );

  always_comb begin
    pick_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[OW'(i)]) pick_id = OW'(i);
    end
  end

  assign mem_addr = busy ? addr_a[owner_id]  : '0;
  assign mem_data = busy ? wdata_a[owner_id] : '0;
  assign mem_wren = busy & wr[owner_id];
  assign rdata    = mem_q;

  // Grant FSM, RR pointer and hold/starvation tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt        <= '0;
      busy       <= 1'b0;
      owner_id   <= '0;
      ptr        <= '0;
      hold       <= '0;
      starve_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= OWN;
            gnt      <= pick;
            busy     <= 1'b1;
            owner_id <= pick_id;
            hold     <= '0;
          end
        end
        OWN: begin
          if (req[owner_id]) begin
            if (MAX_HOLD > 0 && others_req) begin
              if (hold != HW'(MAX_HOLD)) hold <= hold + 1'b1;
              if (hold >= HW'(MAX_HOLD - 1)) starve_err <= 1'b1;
            end
          end else begin
            ptr  <= owner_inc;
            hold <= '0;
            if (found) begin
              gnt      <= pick;
              owner_id <= pick_id;
            end else begin
              state    <= IDLE;
              gnt      <= '0;
              busy     <= 1'b0;
              owner_id <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read tag pipeline: in-flight reads survive grant changes, only reset flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr <= '0;
      idx_sr <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | RD_LATENCY'(busy & rd[owner_id]);
      idx_sr <= (idx_sr << OW) | IW'(owner_id);
    end
  end

  always_comb begin
    rd_valid = '0;
    if (vld_sr[RD_LATENCY-1]) rd_valid[idx_sr[IW-1 -: OW]] = 1'b1;
  end

endmodule
